// File: rtl/bscan_pkg.sv
// ---------------------------------------------------------------------------
// bscan_pkg
//   Shared definitions for the soft JTAG TAP (bscan_virtex):
//   - tap_state_e   : 16 IEEE 1149.1 TAP states, encoded with the Xilinx TAP
//                     state numbering (the 4-bit codes seen in SVF tooling).
//   - DEF_*         : default opcodes and device ID.
//   - IR_CAPTURE_LSB: the fixed '01' pattern loaded at the IR LSBs in
//                     CAPTURE_IR; the upper bits capture as zeros.
// ---------------------------------------------------------------------------
package bscan_pkg;

    typedef enum logic [3:0] {
        TAP_EXIT2_DR         = 4'h0,
        TAP_EXIT1_DR         = 4'h1,
        TAP_SHIFT_DR         = 4'h2,
        TAP_PAUSE_DR         = 4'h3,
        TAP_SELECT_IR        = 4'h4,
        TAP_UPDATE_DR        = 4'h5,
        TAP_CAPTURE_DR       = 4'h6,
        TAP_SELECT_DR        = 4'h7,
        TAP_EXIT2_IR         = 4'h8,
        TAP_EXIT1_IR         = 4'h9,
        TAP_SHIFT_IR         = 4'hA,
        TAP_PAUSE_IR         = 4'hB,
        TAP_RUN_TEST_IDLE    = 4'hC,
        TAP_UPDATE_IR        = 4'hD,
        TAP_CAPTURE_IR       = 4'hE,
        TAP_TEST_LOGIC_RESET = 4'hF
    } tap_state_e;

    localparam logic [4:0]  DEF_USER1_OP   = 5'b00010;
    localparam logic [4:0]  DEF_USER2_OP   = 5'b00011;
    localparam logic [4:0]  DEF_IDCODE_OP  = 5'b01001;
    localparam logic [31:0] DEF_IDCODE_VAL = 32'h0061_8093;

    localparam logic [1:0]  IR_CAPTURE_LSB = 2'b01;

endpackage : bscan_pkg

// File: rtl/bscan_tap_fsm.sv
// ---------------------------------------------------------------------------
// bscan_tap_fsm
//   IEEE 1149.1 TAP controller state machine: state register plus pure
//   next-state logic driven by TMS. Nothing else lives here.
//
//   Ports:
//     i_clk    in   JTAG TCK, state advances on the rising edge
//     i_rst_n  in   asynchronous active-low reset to TEST_LOGIC_RESET
//     i_tms    in   test mode select
//     o_state  out  current TAP state
// ---------------------------------------------------------------------------
module bscan_tap_fsm
    import bscan_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_tms,
    output tap_state_e o_state
);

    tap_state_e r_state;
    tap_state_e w_state_next;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= TAP_TEST_LOGIC_RESET;
        end else begin
            // NOTE: state registers use non-blocking assignment so every
            // flop samples the pre-edge values of its neighbours.
            r_state <= w_state_next;
        end
    end

    always_comb begin
        // NOTE: the default assignment up front means every path through the
        // case assigns w_state_next, so no latch is inferred.
        w_state_next = r_state;
        unique case (r_state)
            TAP_TEST_LOGIC_RESET: w_state_next = i_tms ? TAP_TEST_LOGIC_RESET : TAP_RUN_TEST_IDLE;
            TAP_RUN_TEST_IDLE:    w_state_next = i_tms ? TAP_SELECT_DR        : TAP_RUN_TEST_IDLE;
            TAP_SELECT_DR:        w_state_next = i_tms ? TAP_SELECT_IR        : TAP_CAPTURE_DR;
            TAP_CAPTURE_DR:       w_state_next = i_tms ? TAP_EXIT1_DR         : TAP_SHIFT_DR;
            TAP_SHIFT_DR:         w_state_next = i_tms ? TAP_EXIT1_DR         : TAP_SHIFT_DR;
            TAP_EXIT1_DR:         w_state_next = i_tms ? TAP_UPDATE_DR        : TAP_PAUSE_DR;
            TAP_PAUSE_DR:         w_state_next = i_tms ? TAP_EXIT2_DR         : TAP_PAUSE_DR;
            TAP_EXIT2_DR:         w_state_next = i_tms ? TAP_UPDATE_DR        : TAP_SHIFT_DR;
            TAP_UPDATE_DR:        w_state_next = i_tms ? TAP_SELECT_DR        : TAP_RUN_TEST_IDLE;
            TAP_SELECT_IR:        w_state_next = i_tms ? TAP_TEST_LOGIC_RESET : TAP_CAPTURE_IR;
            TAP_CAPTURE_IR:       w_state_next = i_tms ? TAP_EXIT1_IR         : TAP_SHIFT_IR;
            TAP_SHIFT_IR:         w_state_next = i_tms ? TAP_EXIT1_IR         : TAP_SHIFT_IR;
            TAP_EXIT1_IR:         w_state_next = i_tms ? TAP_UPDATE_IR        : TAP_PAUSE_IR;
            TAP_PAUSE_IR:         w_state_next = i_tms ? TAP_EXIT2_IR         : TAP_PAUSE_IR;
            TAP_EXIT2_IR:         w_state_next = i_tms ? TAP_UPDATE_IR        : TAP_SHIFT_IR;
            TAP_UPDATE_IR:        w_state_next = i_tms ? TAP_SELECT_DR        : TAP_RUN_TEST_IDLE;
            default:              w_state_next = TAP_TEST_LOGIC_RESET;
        endcase
    end

    assign o_state = r_state;

endmodule : bscan_tap_fsm

// File: rtl/bscan_virtex.sv
// ---------------------------------------------------------------------------
// bscan_virtex
//   Soft JTAG TAP exposing two user DR channels (USER1/USER2) to fabric
//   logic, clocked directly by TCK. Holds the IR, bypass register, optional
//   ID register, TDO mux and the DRCK clock gating; the TAP state machine
//   is in bscan_tap_fsm.
//
//   Optional feature macro: BSCAN_IDCODE_EN
//     defined   -> 32-bit ID register, IR resets to IDCODE_OP
//     undefined -> no ID register, IDCODE_OP acts as BYPASS, IR resets to
//                  all-ones
//
//   Ports:
//     CLK     in   JTAG TCK
//     RST_B   in   asynchronous active-low reset
//     TMS     in   test mode select
//     TDI     in   test data in
//     TDO     out  test data out, registered on the falling edge of CLK
//     TDO_OE  out  high while in SHIFT_IR/SHIFT_DR (falling-edge register)
//     DRCK1   out  CLK gated to CAPTURE_DR/SHIFT_DR while USER1 selected
//     DRCK2   out  same as DRCK1 for USER2
//     RESET   out  high in TEST_LOGIC_RESET
//     SEL1    out  IR holds USER1_OP
//     SEL2    out  IR holds USER2_OP
//     SHIFT   out  high in SHIFT_DR
//     BTDI    out  TDI passthrough
//     UPDATE  out  high in UPDATE_DR
//     TDO1    in   serial return from the USER1 register
//     TDO2    in   serial return from the USER2 register
// ---------------------------------------------------------------------------
module bscan_virtex
    import bscan_pkg::*;
#(
    parameter int                IR_LEN     = 5,
    parameter logic [IR_LEN-1:0] USER1_OP   = IR_LEN'(DEF_USER1_OP),
    parameter logic [IR_LEN-1:0] USER2_OP   = IR_LEN'(DEF_USER2_OP),
    parameter logic [IR_LEN-1:0] IDCODE_OP  = IR_LEN'(DEF_IDCODE_OP),
    parameter logic [31:0]       IDCODE_VAL = DEF_IDCODE_VAL
) (
    input  logic CLK,
    input  logic RST_B,
    input  logic TMS,
    input  logic TDI,
    output logic TDO,
    output logic TDO_OE,
    output logic DRCK1,
    output logic DRCK2,
    output logic RESET,
    output logic SEL1,
    output logic SEL2,
    output logic SHIFT,
    output logic BTDI,
    output logic UPDATE,
    input  logic TDO1,
    input  logic TDO2
);

    localparam logic [IR_LEN-1:0] IR_CAP_VAL = {{(IR_LEN-2){1'b0}}, IR_CAPTURE_LSB};
`ifdef BSCAN_IDCODE_EN
    localparam logic [IR_LEN-1:0] IR_RST_VAL = IDCODE_OP;
`else
    localparam logic [IR_LEN-1:0] IR_RST_VAL = {IR_LEN{1'b1}};
`endif

    tap_state_e        w_state;
    logic [IR_LEN-1:0] r_ir_sr;
    logic [IR_LEN-1:0] r_ir;
    logic              r_bypass;
    logic              r_tdo;
    logic              r_tdo_oe;
    logic              w_tdo_next;
    logic              w_shift_any;
    logic              w_dr_clk_win;
    logic              w_sel1;
    logic              w_sel2;
    logic              w_sel_id;

    bscan_tap_fsm u_tap_fsm (
        .i_clk   (CLK),
        .i_rst_n (RST_B),
        .i_tms   (TMS),
        .o_state (w_state)
    );

    // Instruction register. The shift stage is reset as well so an aborted
    // scan leaves nothing behind that a later UPDATE_IR could pick up.
    always_ff @(posedge CLK or negedge RST_B) begin
        if (!RST_B) begin
            r_ir_sr <= IR_CAP_VAL;
            r_ir    <= IR_RST_VAL;
        end else begin
            unique case (w_state)
                TAP_TEST_LOGIC_RESET: r_ir    <= IR_RST_VAL;
                TAP_CAPTURE_IR:       r_ir_sr <= IR_CAP_VAL;
                TAP_SHIFT_IR:         r_ir_sr <= {TDI, r_ir_sr[IR_LEN-1:1]};
                TAP_UPDATE_IR:        r_ir    <= r_ir_sr;
                default: ;
            endcase
        end
    end

    // Single-bit bypass register: one TCK of delay from TDI to TDO.
    always_ff @(posedge CLK or negedge RST_B) begin
        if (!RST_B) begin
            r_bypass <= 1'b0;
        end else if (w_state == TAP_CAPTURE_DR) begin
            r_bypass <= 1'b0;
        end else if (w_state == TAP_SHIFT_DR) begin
            r_bypass <= TDI;
        end
    end

    assign w_sel1 = (r_ir == USER1_OP);
    assign w_sel2 = (r_ir == USER2_OP);

`ifdef BSCAN_IDCODE_EN
    logic [31:0] r_idcode;

    assign w_sel_id = (r_ir == IDCODE_OP);

    // ID register: captures the device ID and shifts out LSB-first.
    always_ff @(posedge CLK or negedge RST_B) begin
        if (!RST_B) begin
            r_idcode <= IDCODE_VAL;
        end else if (w_state == TAP_CAPTURE_DR) begin
            r_idcode <= IDCODE_VAL;
        end else if (w_state == TAP_SHIFT_DR && w_sel_id) begin
            r_idcode <= {TDI, r_idcode[31:1]};
        end
    end
`else
    // Without the ID register the IDCODE opcode falls through to BYPASS.
    logic w_unused_idcode_cfg;

    assign w_sel_id            = 1'b0;
    assign w_unused_idcode_cfg = ^{IDCODE_VAL, IDCODE_OP};
`endif

    // TDO source select; data is launched on the falling edge below.
    always_comb begin
        w_tdo_next = 1'b0;
        if (w_state == TAP_SHIFT_IR) begin
            w_tdo_next = r_ir_sr[0];
        end else if (w_state == TAP_SHIFT_DR) begin
            if (w_sel1) begin
                w_tdo_next = TDO1;
            end else if (w_sel2) begin
                w_tdo_next = TDO2;
            end else if (w_sel_id) begin
`ifdef BSCAN_IDCODE_EN
                w_tdo_next = r_idcode[0];
`else
                w_tdo_next = r_bypass;
`endif
            end else begin
                w_tdo_next = r_bypass;
            end
        end
    end

    assign w_shift_any = (w_state == TAP_SHIFT_IR) || (w_state == TAP_SHIFT_DR);

    // Falling-edge output stage gives the downstream device half a TCK of
    // setup before it samples TDO on the next rising edge.
    always_ff @(negedge CLK or negedge RST_B) begin
        if (!RST_B) begin
            r_tdo    <= 1'b0;
            r_tdo_oe <= 1'b0;
        end else begin
            r_tdo    <= w_tdo_next;
            r_tdo_oe <= w_shift_any;
        end
    end

    // The gate only changes on the rising edge while CLK is already high,
    // so forcing the output to 1 when closed cannot produce a runt pulse.
    assign w_dr_clk_win = (w_state == TAP_CAPTURE_DR) || (w_state == TAP_SHIFT_DR);
    assign DRCK1        = (w_sel1 && w_dr_clk_win) ? CLK : 1'b1;
    assign DRCK2        = (w_sel2 && w_dr_clk_win) ? CLK : 1'b1;

    assign TDO    = r_tdo;
    assign TDO_OE = r_tdo_oe;
    assign RESET  = (w_state == TAP_TEST_LOGIC_RESET);
    assign SEL1   = w_sel1;
    assign SEL2   = w_sel2;
    assign SHIFT  = (w_state == TAP_SHIFT_DR);
    assign UPDATE = (w_state == TAP_UPDATE_DR);
    assign BTDI   = TDI;

endmodule : bscan_virtex

// File: tb/tb_bscan_virtex.sv
// ---------------------------------------------------------------------------
// tb_bscan_virtex
//   Directed bench for bscan_virtex. Inputs change 1 time unit after the
//   rising edge; TDO is read 1 unit after the falling edge.
// ---------------------------------------------------------------------------
module tb_bscan_virtex;

    logic CLK = 1'b0;
    logic RST_B;
    logic TMS;
    logic TDI;
    logic TDO1;
    logic TDO2;
    logic TDO;
    logic TDO_OE;
    logic DRCK1;
    logic DRCK2;
    logic RESET;
    logic SEL1;
    logic SEL2;
    logic SHIFT;
    logic BTDI;
    logic UPDATE;

    int n_checks = 0;
    int n_fail   = 0;

    int n_drck1_pulses  = 0;
    int n_drck2_pulses  = 0;
    int n_shift_cycles  = 0;
    int n_update_cycles = 0;

    logic g_oe;

    bscan_virtex dut (
        .CLK    (CLK),
        .RST_B  (RST_B),
        .TMS    (TMS),
        .TDI    (TDI),
        .TDO    (TDO),
        .TDO_OE (TDO_OE),
        .DRCK1  (DRCK1),
        .DRCK2  (DRCK2),
        .RESET  (RESET),
        .SEL1   (SEL1),
        .SEL2   (SEL2),
        .SHIFT  (SHIFT),
        .BTDI   (BTDI),
        .UPDATE (UPDATE),
        .TDO1   (TDO1),
        .TDO2   (TDO2)
    );

    always #5 CLK = ~CLK;

    always @(negedge DRCK1) n_drck1_pulses++;
    always @(negedge DRCK2) n_drck2_pulses++;
    always @(negedge CLK) begin
        if (SHIFT)  n_shift_cycles++;
        if (UPDATE) n_update_cycles++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One TCK with the given TMS/TDI; returns TDO as seen after the falling
    // edge of this cycle. Entered and left 1 unit after a rising edge.
    task automatic tck(input logic tms, input logic tdi, output logic tdo_s);
        TMS = tms;
        TDI = tdi;
        @(negedge CLK);
        #1;
        tdo_s = TDO;
        g_oe  = TDO_OE;
        @(posedge CLK);
        #1;
    endtask

    // From RUN_TEST_IDLE: load IR with v, return the captured IR bits.
    task automatic scan_ir(input logic [4:0] v, output logic [4:0] cap);
        logic b;
        tck(1'b1, 1'b0, b);
        tck(1'b1, 1'b0, b);
        tck(1'b0, 1'b0, b);
        tck(1'b0, 1'b0, b);
        for (int i = 0; i < 5; i++) begin
            tck(i == 4, v[i], b);
            cap[i] = b;
        end
        tck(1'b1, 1'b0, b);
        tck(1'b0, 1'b0, b);
    endtask

    // From RUN_TEST_IDLE: n-bit DR scan. 'which' selects which user return
    // line carries ret_v; the other carries its inverse so a wrong mux
    // choice shows up. Returns the TDO bits and the AND of TDO_OE over the
    // shift cycles.
    task automatic scan_dr(input int n, input logic [31:0] tdi_v, input logic [31:0] ret_v,
                           input int which, output logic [31:0] tdo_v, output logic oe_all);
        logic b;
        tdo_v  = '0;
        oe_all = 1'b1;
        tck(1'b1, 1'b0, b);
        tck(1'b0, 1'b0, b);
        tck(1'b0, 1'b0, b);
        for (int i = 0; i < n; i++) begin
            TDO1 = (which == 1) ? ret_v[i] : ~ret_v[i];
            TDO2 = (which == 2) ? ret_v[i] : ~ret_v[i];
            tck(i == n - 1, tdi_v[i], b);
            tdo_v[i] = b;
            oe_all   = oe_all & g_oe;
        end
        tck(1'b1, 1'b0, b);
        tck(1'b0, 1'b0, b);
    endtask

    initial begin
        logic        b;
        logic        oe;
        logic [4:0]  cap;
        logic [31:0] tv;
        int          d1, d2, ds, du;

        RST_B = 1'b0;
        TMS   = 1'b0;
        TDI   = 1'b0;
        TDO1  = 1'b0;
        TDO2  = 1'b0;
        g_oe  = 1'b0;

        repeat (3) @(posedge CLK);
        #1;
        check("rst_RESET",  32'(RESET),  32'd1);
        check("rst_SEL1",   32'(SEL1),   32'd0);
        check("rst_SEL2",   32'(SEL2),   32'd0);
        check("rst_DRCK1",  32'(DRCK1),  32'd1);
        check("rst_DRCK2",  32'(DRCK2),  32'd1);
        check("rst_TDO_OE", 32'(TDO_OE), 32'd0);
        check("rst_TDO",    32'(TDO),    32'd0);
        check("rst_SHIFT",  32'(SHIFT),  32'd0);
        check("rst_UPDATE", 32'(UPDATE), 32'd0);

        RST_B = 1'b1;
        tck(1'b0, 1'b0, b);
        check("rti_RESET", 32'(RESET), 32'd0);

        TDI = 1'b1;
        #1;
        check("btdi_pass", 32'(BTDI), 32'd1);

        // IR capture pattern and BYPASS load.
        scan_ir(5'b11111, cap);
        check("ir_capture", 32'(cap), 32'b00001);
        check("bypass_SEL1", 32'(SEL1), 32'd0);
        check("bypass_SEL2", 32'(SEL2), 32'd0);

        // TDI 1,0,1,1 -> TDO 0,1,0,1 (bit0 first).
        scan_dr(4, 32'b1101, 32'b1111, 0, tv, oe);
        check("bypass_tdo", tv, 32'b1010);
        check("bypass_oe",  32'(oe), 32'd1);

        // USER1 channel.
        scan_ir(5'b00010, cap);
        check("u1_SEL1", 32'(SEL1), 32'd1);
        check("u1_SEL2", 32'(SEL2), 32'd0);
        d1 = n_drck1_pulses; d2 = n_drck2_pulses;
        ds = n_shift_cycles; du = n_update_cycles;
        scan_dr(8, 32'h5A, 32'b1001_0110, 1, tv, oe);
        check("u1_tdo",      tv, 32'b1001_0110);
        check("u1_drck1",    32'(n_drck1_pulses - d1), 32'd9);
        check("u1_drck2",    32'(n_drck2_pulses - d2), 32'd0);
        check("u1_shift",    32'(n_shift_cycles - ds), 32'd8);
        check("u1_update",   32'(n_update_cycles - du), 32'd1);
        check("u1_sel_hold", 32'(SEL1), 32'd1);

        // USER2 channel.
        scan_ir(5'b00011, cap);
        check("u2_SEL2", 32'(SEL2), 32'd1);
        check("u2_SEL1", 32'(SEL1), 32'd0);
        d1 = n_drck1_pulses; d2 = n_drck2_pulses;
        scan_dr(6, 32'h0, 32'b10_1100, 2, tv, oe);
        check("u2_tdo",   tv, 32'b10_1100);
        check("u2_drck1", 32'(n_drck1_pulses - d1), 32'd0);
        check("u2_drck2", 32'(n_drck2_pulses - d2), 32'd7);

        // Unrecognised opcode behaves as BYPASS: TDI 0,1,1,0 -> TDO 0,0,1,1.
        scan_ir(5'b10101, cap);
        scan_dr(4, 32'b0110, 32'b0000, 0, tv, oe);
        check("unk_bypass", tv, 32'b1100);

        // Five TMS=1 clocks from SHIFT_DR reach TEST_LOGIC_RESET.
        scan_ir(5'b00010, cap);
        tck(1'b1, 1'b0, b);
        tck(1'b0, 1'b0, b);
        tck(1'b0, 1'b0, b);
        check("tms5_in_shift", 32'(SHIFT), 32'd1);
        repeat (5) tck(1'b1, 1'b0, b);
        check("tms5_RESET", 32'(RESET), 32'd1);
        tck(1'b0, 1'b0, b);
        check("tms5_ir_reset_SEL1", 32'(SEL1), 32'd0);

        // RST_B mid IR scan aborts at once.
        scan_ir(5'b00011, cap);
        tck(1'b1, 1'b0, b);
        tck(1'b1, 1'b0, b);
        tck(1'b0, 1'b0, b);
        tck(1'b0, 1'b0, b);
        tck(1'b0, 1'b1, b);
        check("abort_oe_before", 32'(g_oe), 32'd1);
        RST_B = 1'b0;
        #1;
        check("abort_RESET",  32'(RESET),  32'd1);
        check("abort_TDO_OE", 32'(TDO_OE), 32'd0);
        check("abort_SEL2",   32'(SEL2),   32'd0);
        @(posedge CLK);
        #1;
        RST_B = 1'b1;
        tck(1'b0, 1'b0, b);

`ifdef BSCAN_IDCODE_EN
        scan_dr(32, 32'h0, 32'h0, 0, tv, oe);
        check("idcode_value", tv, 32'h0061_8093);
`else
        // No ID register: IR resets to BYPASS and IDCODE_OP acts as BYPASS.
        scan_dr(4, 32'b0110, 32'b0000, 0, tv, oe);
        check("noid_reset_bypass", tv, 32'b1100);
        scan_ir(5'b01001, cap);
        scan_dr(4, 32'b1101, 32'b0000, 0, tv, oe);
        check("noid_op_bypass", tv, 32'b1010);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_bscan_virtex
